// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, counter width and baud divisor helper.
package uart_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

   function automatic int unsigned calc_bps_cnt(input int unsigned clk_freq,
                                                input int unsigned bps);
      return clk_freq / bps;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..BPS_CNT-1 while enabled, strobes bit_end on the last count.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned BPS_CNT = 5208
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic en,
   output logic bit_end,
   output logic bit_pre
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BPS_CNT - 2);

   logic [CNT_W-1:0] clk_cnt;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         clk_cnt <= '0;
      end else if (!en || clk_cnt == CNT_LAST) begin
         clk_cnt <= '0;
      end else begin
         clk_cnt <= clk_cnt + 1'b1;
      end
   end

   // bit_pre lets the parent register a pulse that lands in the final clock of a bit
   assign bit_end = en && (clk_cnt == CNT_LAST);
   assign bit_pre = en && (clk_cnt == CNT_PRE);

endmodule

// File: rtl/uart_send.sv
// UART transmitter, 8N1 LSB first; define UART_SEND_PARITY_EN to insert an even parity bit.
//
//   state  | meaning
//   IDLE   | line high, tx_ready high, waiting for tx_valid
//   START  | start bit (low) for one bit period
//   DATA   | eight data bits, LSB first
//   PARITY | even parity of the latched byte (UART_SEND_PARITY_EN only)
//   STOP   | stop bit (high); tx_done in its final clock
module uart_send
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50000000,
   parameter int unsigned UART_BPS = 9600
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       uart_txd
);

   localparam int unsigned BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);

   generate
      if (BPS_CNT < 2 || BPS_CNT > 65535) begin : g_bps_range
         $error("uart_send: BPS_CNT out of range 2..65535");
      end
   endgenerate

   uart_state_e state;
   logic [7:0]  shift_reg;
   logic [2:0]  bit_idx;
   logic        bit_end;
   logic        bit_pre;
`ifdef UART_SEND_PARITY_EN
   logic        parity_bit;
`endif

   uart_baud_tick #(
      .BPS_CNT (BPS_CNT)
   ) u_baud_tick (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .en      (state != IDLE),
      .bit_end (bit_end),
      .bit_pre (bit_pre)
   );

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_idx   <= '0;
         uart_txd  <= 1'b1;
         tx_ready  <= 1'b1;
         tx_busy   <= 1'b0;
         tx_done   <= 1'b0;
`ifdef UART_SEND_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               if (tx_valid && tx_ready) begin
                  shift_reg <= tx_data;
                  bit_idx   <= '0;
                  uart_txd  <= 1'b0;
                  tx_ready  <= 1'b0;
                  tx_busy   <= 1'b1;
                  state     <= START;
`ifdef UART_SEND_PARITY_EN
                  parity_bit <= ^tx_data;
`endif
               end
            end
            START: begin
               if (bit_end) begin
                  uart_txd  <= shift_reg[0];
                  shift_reg <= {1'b0, shift_reg[7:1]};
                  state     <= DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_idx == 3'd7) begin
`ifdef UART_SEND_PARITY_EN
                     uart_txd <= parity_bit;
                     state    <= PARITY;
`else
                     uart_txd <= 1'b1;
                     state    <= STOP;
`endif
                  end else begin
                     uart_txd  <= shift_reg[0];
                     shift_reg <= {1'b0, shift_reg[7:1]};
                  end
                  bit_idx <= bit_idx + 3'd1;
               end
            end
`ifdef UART_SEND_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  uart_txd <= 1'b1;
                  state    <= STOP;
               end
            end
`endif
            STOP: begin
               if (bit_pre) begin
                  tx_done <= 1'b1;
               end
               if (bit_end) begin
                  tx_ready <= 1'b1;
                  tx_busy  <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: begin
               uart_txd <= 1'b1;
               tx_ready <= 1'b1;
               tx_busy  <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_send.sv
// Self-checking bench for uart_send: frame-level reference model, loopback receiver, directed cases.
module tb_uart_send;

   // 50 MHz / 3 Mbaud truncates to 16 clocks per bit
   localparam int unsigned CLK_FREQ = 50000000;
   localparam int unsigned UART_BPS = 3000000;
   localparam int B = 16;
`ifdef UART_SEND_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       sys_clk;
   logic       sys_rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_busy;
   logic       tx_done;
   logic       uart_txd;

   uart_send #(
      .CLK_FREQ (CLK_FREQ),
      .UART_BPS (UART_BPS)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done),
      .uart_txd (uart_txd)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit cmp_en   = 1'b0;

   always @(posedge sys_clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a frame is a list of NB line levels, each held B clocks
   int   m_pos = -1;
   logic m_bits [0:10];

   always @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         m_pos = -1;
      end else if (m_pos < 0) begin
         if (tx_valid) begin
            m_bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) m_bits[i+1] = tx_data[i];
`ifdef UART_SEND_PARITY_EN
            m_bits[9]  = ^tx_data;
            m_bits[10] = 1'b1;
`else
            m_bits[9]  = 1'b1;
`endif
            m_pos = 0;
         end
      end else if (m_pos == NB*B - 1) begin
         m_pos = -1;
      end else begin
         m_pos++;
      end
   end

   always @(negedge sys_clk) begin
      if (cmp_en) begin
         check("line",  {31'd0, uart_txd}, (m_pos < 0) ? 32'd1 : {31'd0, m_bits[m_pos / B]});
         check("ready", {31'd0, tx_ready}, (m_pos < 0) ? 32'd1 : 32'd0);
         check("busy",  {31'd0, tx_busy},  (m_pos < 0) ? 32'd0 : 32'd1);
         check("done",  {31'd0, tx_done},  (m_pos == NB*B - 1) ? 32'd1 : 32'd0);
      end
   end

   // Loopback receiver sampling at bit centres
   logic [7:0] rx_q [$];
   logic [7:0] rx_byte;
   logic       rx_par;
   bit         rx_on = 1'b0;
   int         rx_cnt;
   int         frame_err = 0;

   always @(negedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         rx_on = 1'b0;
      end else if (!rx_on) begin
         if (uart_txd === 1'b0) begin
            rx_on  = 1'b1;
            rx_cnt = 0;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt % B == B/2 && rx_cnt < 9*B)
            rx_byte[(rx_cnt - B - B/2) / B] = uart_txd;
`ifdef UART_SEND_PARITY_EN
         if (rx_cnt == 9*B + B/2) rx_par = uart_txd;
`endif
         if (rx_cnt == (NB-1)*B + B/2) begin
            if (uart_txd === 1'b1) rx_q.push_back(rx_byte);
            else frame_err++;
            rx_on = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) step();
   endtask

   // Presents a byte for one accept; returns the cycle number of the first low cycle
   task automatic send(input logic [7:0] d, output int t0);
      tx_valid = 1'b1;
      tx_data  = d;
      check("ready_before_send", {31'd0, tx_ready}, 32'd1);
      step();
      tx_valid = 1'b0;
      t0 = cyc;
      check("start_low", {31'd0, uart_txd}, 32'd0);
   endtask

   task automatic wait_done(output int t_done);
      int n;
      n = 0;
      t_done = -1;
      while (n < 20*B && t_done < 0) begin
         if (tx_done === 1'b1) t_done = cyc;
         else step();
         n++;
      end
      if (t_done < 0) begin
         checks++;
         failures++;
         $display("FAIL done_timeout actual=none required=pulse within %0d clocks", 20*B);
      end
   endtask

   task automatic pop_check(input string name, input logic [7:0] exp);
      if (rx_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s actual=empty required=%0h", name, exp);
      end else begin
         check(name, {24'd0, rx_q.pop_front()}, {24'd0, exp});
      end
   endtask

`ifdef UART_SEND_PARITY_EN
   localparam int FRAME_CLKS = 176;
   localparam logic [10:0] A5_LINE = 11'b11_0101_0010_1_0 >> 0;
`else
   localparam int FRAME_CLKS = 160;
`endif

   initial begin
      int t0, td, t1, n;
      logic [10:0] a5_line;

      // start, 1,0,1,0,0,1,0,1, (parity 0,) stop
`ifdef UART_SEND_PARITY_EN
      a5_line = 11'b1_0_10100101_0;
`else
      a5_line = 11'b0_1_10100101_0;
`endif

      sys_rst  = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      #2 sys_rst = 1'b1;
      #1 cmp_en = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1 sys_rst = 1'b0;

      repeat (100) step();
      check("idle_txd",   {31'd0, uart_txd}, 32'd1);
      check("idle_ready", {31'd0, tx_ready}, 32'd1);
      check("idle_busy",  {31'd0, tx_busy},  32'd0);
      check("idle_done",  {31'd0, tx_done},  32'd0);

      // single byte 0xA5
      send(8'hA5, t0);
      for (int k = 1; k < NB; k++) begin
         wait_cyc(t0 + k*B + B/2);
         check("a5_bit", {31'd0, uart_txd}, {31'd0, a5_line[k]});
      end
      wait_done(td);
      check("a5_frame_len", td - t0 + 1, FRAME_CLKS);
      pop_check("a5_rx", 8'hA5);
      step();

      // back-to-back 0x00 then 0xFF with tx_valid held
      tx_valid = 1'b1;
      tx_data  = 8'h00;
      step();
      t0 = cyc;
      tx_data = 8'hFF;
      wait_done(td);
      n = 0;
      t1 = -1;
      while (n < 4 && t1 < 0) begin
         step();
         if (uart_txd === 1'b0) t1 = cyc;
         n++;
      end
      tx_valid = 1'b0;
      check("b2b_gap", t1 - td, 2);
      wait_done(td);
      check("b2b_len", td - t1 + 1, FRAME_CLKS);
      pop_check("b2b_rx0", 8'h00);
      pop_check("b2b_rx1", 8'hFF);
      step();

      // request during DATA is ignored
      send(8'h81, t0);
      wait_cyc(t0 + 3*B);
      tx_valid = 1'b1;
      tx_data  = 8'h3C;
      check("busy_not_ready", {31'd0, tx_ready}, 32'd0);
      step();
      tx_valid = 1'b0;
      wait_done(td);
      check("81_frame_len", td - t0 + 1, FRAME_CLKS);
      pop_check("81_rx", 8'h81);
      repeat (3*B) step();
      check("ignored_none", rx_q.size(), 0);

      // async reset mid-DATA of 0x55
      send(8'h55, t0);
      wait_cyc(t0 + 4*B + 3);
      @(negedge sys_clk);
      #2 sys_rst = 1'b1;
      #1;
      check("rst_txd",   {31'd0, uart_txd}, 32'd1);
      check("rst_busy",  {31'd0, tx_busy},  32'd0);
      check("rst_ready", {31'd0, tx_ready}, 32'd1);
      repeat (2) @(posedge sys_clk);
      #1 sys_rst = 1'b0;
      step();
      check("rst_no_rx", rx_q.size(), 0);
      send(8'h55, t0);
      wait_done(td);
      check("55_frame_len", td - t0 + 1, FRAME_CLKS);
      pop_check("55_rx", 8'h55);
      step();

      // 0x07: three ones, parity bit 1 when enabled
      send(8'h07, t0);
      wait_done(td);
      check("07_frame_len", td - t0 + 1, FRAME_CLKS);
      pop_check("07_rx", 8'h07);
`ifdef UART_SEND_PARITY_EN
      check("07_parity", {31'd0, rx_par}, 32'd1);
`endif
      repeat (4) step();
      check("frame_errors", frame_err, 0);

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=still running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
